// File: rtl/sfft_frame_engine.sv
// Frame controller and output integrator for the stochastic FFT butterfly network.
// Loads per-stage twiddles, sequences clear/run for one bitstream frame, and counts output ones.
module sfft_frame_engine #(
  parameter int BITWIDTH  = 8,
  parameter int NUMINPUTS = 4,
  parameter int LOG2N     = $clog2(NUMINPUTS),
  parameter int STREAMLEN = 256,
  parameter int CORELAT   = 2,
  parameter int CNTW      = $clog2(STREAMLEN + 1)
) (
  input  logic                        iClk,
  input  logic                        iRstN,
  input  logic                        iStart,
  input  logic                        iKeepW,
  input  logic                        iAbort,
  input  logic                        iWValid,
  input  logic [BITWIDTH-1:0]         iWReal,
  input  logic [BITWIDTH-1:0]         iWImg,
  output logic                        oWReady,
  output logic [LOG2N*BITWIDTH-1:0]   oTwReal,
  output logic [LOG2N*BITWIDTH-1:0]   oTwImg,
  output logic                        oCoreEn,
  output logic                        oCoreClr,
  output logic                        oCoreLoadW,
  input  logic [NUMINPUTS-1:0]        iCoreReal,
  input  logic [NUMINPUTS-1:0]        iCoreImg,
  output logic [NUMINPUTS*CNTW-1:0]   oAccReal,
  output logic [NUMINPUTS*CNTW-1:0]   oAccImg,
  output logic                        oBusy,
  output logic                        oValid,
  output logic                        oDone
);

  localparam int RUNLEN = CORELAT + STREAMLEN;
  localparam int RW     = $clog2(RUNLEN);
  localparam int WW     = (LOG2N > 1) ? $clog2(LOG2N) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, CLEAR, RUN, DONE} state_t;

  state_t        state, nextstate;
  logic [RW-1:0] runcnt;
  logic [WW-1:0] widx;
  logic          startgo, accept, lastword, lastrun, counting;

  // Abort outranks everything, so every qualifier that changes state masks it out.
  assign startgo  = (state == IDLE) && iStart && !iAbort;
  assign accept   = oWReady && iWValid && !iAbort;
  assign lastword = (widx == WW'(LOG2N - 1));
  assign lastrun  = (runcnt == RW'(RUNLEN - 1));
  assign counting = (state == RUN) && !iAbort && (runcnt >= RW'(CORELAT));

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) state <= IDLE;
    else        state <= nextstate;
  end

  always_comb begin
    nextstate = state;
    if (iAbort && state != IDLE) begin
      nextstate = IDLE;
    end else begin
      case (state)
        IDLE:    if (startgo) nextstate = iKeepW ? CLEAR : LOAD;
        LOAD:    if (accept && lastword) nextstate = CLEAR;
        CLEAR:   nextstate = RUN;
        RUN:     if (lastrun) nextstate = DONE;
        DONE:    nextstate = IDLE;
        default: nextstate = IDLE;
      endcase
    end
  end

  // Control outputs are decoded from the next state so they are registered yet aligned with state.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      oWReady    <= 1'b0;
      oCoreClr   <= 1'b0;
      oCoreLoadW <= 1'b0;
      oCoreEn    <= 1'b0;
      oDone      <= 1'b0;
      oBusy      <= 1'b0;
    end else begin
      oWReady    <= (nextstate == LOAD);
      oCoreClr   <= (nextstate == CLEAR);
      oCoreLoadW <= (nextstate == CLEAR);
      oCoreEn    <= (nextstate == RUN);
      oDone      <= (nextstate == DONE);
      oBusy      <= (nextstate != IDLE);
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      runcnt   <= '0;
      widx     <= '0;
      oValid   <= 1'b0;
      oTwReal  <= '0;
      oTwImg   <= '0;
      oAccReal <= '0;
      oAccImg  <= '0;
    end else begin
      runcnt <= (state == RUN && !iAbort && !lastrun) ? runcnt + 1'b1 : '0;
      if (startgo) begin
        oValid   <= 1'b0;
        oAccReal <= '0;
        oAccImg  <= '0;
        widx     <= '0;
      end else begin
        if (state == DONE && !iAbort) oValid <= 1'b1;
        if (accept) begin
          oTwReal[int'(widx)*BITWIDTH +: BITWIDTH] <= iWReal;
          oTwImg[int'(widx)*BITWIDTH +: BITWIDTH]  <= iWImg;
          widx <= widx + 1'b1;
        end
        // Leading CORELAT run cycles are pipeline fill and are not counted.
        if (counting) begin
          for (int k = 0; k < NUMINPUTS; k++) begin
            oAccReal[k*CNTW +: CNTW] <= oAccReal[k*CNTW +: CNTW] + CNTW'(iCoreReal[k]);
            oAccImg[k*CNTW +: CNTW]  <= oAccImg[k*CNTW +: CNTW] + CNTW'(iCoreImg[k]);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sfft_frame_engine.sv
// Self-checking bench for sfft_frame_engine: directed frames plus random traffic
// compared every cycle against a frame-level behavioural model.
module tb_sfft_frame_engine;

  localparam int BITWIDTH  = 8;
  localparam int NUMINPUTS = 4;
  localparam int LOG2N     = 2;
  localparam int STREAMLEN = 16;
  localparam int CORELAT   = 2;
  localparam int CNTW      = 5;
  localparam int RUNLEN    = CORELAT + STREAMLEN;

  localparam int P_IDLE  = 0;
  localparam int P_LOAD  = 1;
  localparam int P_CLEAR = 2;
  localparam int P_RUN   = 3;
  localparam int P_DONE  = 4;

  logic                      iClk, iRstN;
  logic                      iStart, iKeepW, iAbort, iWValid;
  logic [BITWIDTH-1:0]       iWReal, iWImg;
  logic                      oWReady, oCoreEn, oCoreClr, oCoreLoadW;
  logic [LOG2N*BITWIDTH-1:0] oTwReal, oTwImg;
  logic [NUMINPUTS-1:0]      iCoreReal, iCoreImg;
  logic [NUMINPUTS*CNTW-1:0] oAccReal, oAccImg;
  logic                      oBusy, oValid, oDone;

  sfft_frame_engine #(
    .BITWIDTH(BITWIDTH), .NUMINPUTS(NUMINPUTS), .LOG2N(LOG2N),
    .STREAMLEN(STREAMLEN), .CORELAT(CORELAT), .CNTW(CNTW)
  ) dut (
    .iClk(iClk), .iRstN(iRstN), .iStart(iStart), .iKeepW(iKeepW), .iAbort(iAbort),
    .iWValid(iWValid), .iWReal(iWReal), .iWImg(iWImg), .oWReady(oWReady),
    .oTwReal(oTwReal), .oTwImg(oTwImg), .oCoreEn(oCoreEn), .oCoreClr(oCoreClr),
    .oCoreLoadW(oCoreLoadW), .iCoreReal(iCoreReal), .iCoreImg(iCoreImg),
    .oAccReal(oAccReal), .oAccImg(oAccImg), .oBusy(oBusy), .oValid(oValid), .oDone(oDone)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  int checks = 0;
  int failures = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: phase, words loaded, run cycle index, twiddle and count arrays.
  int        mphase = P_IDLE;
  int        mwords = 0;
  int        mrunc = 0;
  bit        mvalid = 1'b0;
  logic [7:0] mtwr [LOG2N];
  logic [7:0] mtwi [LOG2N];
  int        maccr [NUMINPUTS];
  int        macci [NUMINPUTS];

  always @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      mphase = P_IDLE; mwords = 0; mrunc = 0; mvalid = 1'b0;
      for (int s = 0; s < LOG2N; s++) begin mtwr[s] = 8'h00; mtwi[s] = 8'h00; end
      for (int k = 0; k < NUMINPUTS; k++) begin maccr[k] = 0; macci[k] = 0; end
    end else if (iAbort && mphase != P_IDLE) begin
      mphase = P_IDLE;
    end else begin
      case (mphase)
        P_IDLE: if (iStart && !iAbort) begin
          mvalid = 1'b0;
          mwords = 0;
          for (int k = 0; k < NUMINPUTS; k++) begin maccr[k] = 0; macci[k] = 0; end
          mphase = iKeepW ? P_CLEAR : P_LOAD;
        end
        P_LOAD: if (iWValid) begin
          mtwr[mwords] = iWReal;
          mtwi[mwords] = iWImg;
          mwords++;
          if (mwords == LOG2N) mphase = P_CLEAR;
        end
        P_CLEAR: begin mrunc = 0; mphase = P_RUN; end
        P_RUN: begin
          if (mrunc >= CORELAT) begin
            for (int k = 0; k < NUMINPUTS; k++) begin
              maccr[k] += int'(iCoreReal[k]);
              macci[k] += int'(iCoreImg[k]);
            end
          end
          mrunc++;
          if (mrunc == RUNLEN) mphase = P_DONE;
        end
        P_DONE: begin mvalid = 1'b1; mphase = P_IDLE; end
        default: mphase = P_IDLE;
      endcase
    end
  end

  function automatic logic [63:0] expTw(input bit im);
    logic [63:0] v;
    v = '0;
    for (int s = 0; s < LOG2N; s++) v[s*BITWIDTH +: BITWIDTH] = im ? mtwi[s] : mtwr[s];
    return v;
  endfunction

  function automatic logic [63:0] expAcc(input bit im);
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < NUMINPUTS; k++) v[k*CNTW +: CNTW] = CNTW'(im ? macci[k] : maccr[k]);
    return v;
  endfunction

  // Every-cycle comparison of all outputs against the model.
  always @(negedge iClk) begin
    checkOutput("wready",  oWReady,    mphase == P_LOAD);
    checkOutput("coreclr", oCoreClr,   mphase == P_CLEAR);
    checkOutput("loadw",   oCoreLoadW, mphase == P_CLEAR);
    checkOutput("coreen",  oCoreEn,    mphase == P_RUN);
    checkOutput("done",    oDone,      mphase == P_DONE);
    checkOutput("busy",    oBusy,      mphase != P_IDLE);
    checkOutput("valid",   oValid,     mvalid);
    checkOutput("twreal",  oTwReal,    expTw(1'b0));
    checkOutput("twimg",   oTwImg,     expTw(1'b1));
    checkOutput("accreal", oAccReal,   expAcc(1'b0));
    checkOutput("accimg",  oAccImg,    expAcc(1'b1));
  end

  int enCount = 0, doneCount = 0, clrCount = 0, loadwCount = 0, wreadyCount = 0;
  always @(negedge iClk) begin
    if (oCoreEn)    enCount++;
    if (oDone)      doneCount++;
    if (oCoreClr)   clrCount++;
    if (oCoreLoadW) loadwCount++;
    if (oWReady)    wreadyCount++;
  end

  int sEn, sDone, sClr, sLoadw, sWready;

  task automatic snap();
    sEn = enCount; sDone = doneCount; sClr = clrCount; sLoadw = loadwCount; sWready = wreadyCount;
  endtask

  task automatic tick();
    @(negedge iClk);
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic applyStimulus(input bit start, input bit keepw, input bit abort, input bit wvalid,
                               input logic [7:0] wr, input logic [7:0] wi);
    iStart = start; iKeepW = keepw; iAbort = abort; iWValid = wvalid; iWReal = wr; iWImg = wi;
  endtask

  // mode 0: core inputs held; 1: real ch0 high only at r=0,1,17; 3: stray iStart at r=8
  task automatic runFrame(input int mode);
    bit finished;
    finished = 1'b0;
    for (int i = 0; i < 200 && !finished; i++) begin
      tick();
      if (mode == 1) iCoreReal = {3'b000, (mphase == P_RUN && (mrunc < 2 || mrunc == 17))};
      if (mode == 3) iStart = (mphase == P_RUN && mrunc == 8);
      if (mphase == P_IDLE) finished = 1'b1;
    end
    iStart = 1'b0;
    checkOutput("frame_timeout", finished, 1'b1);
  endtask

  task automatic waitRun(input int r);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (mphase == P_RUN && mrunc == r) found = 1'b1;
    end
    checkOutput("waitrun_timeout", found, 1'b1);
  endtask

  initial begin
    iRstN = 1'b0;
    applyStimulus(0, 0, 0, 0, 8'h00, 8'h00);
    iCoreReal = '0; iCoreImg = '0;

    // Reset with random inputs
    repeat (6) begin
      tick();
      applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 1) == 1, 8'($urandom), 8'($urandom));
      iCoreReal = 4'($urandom); iCoreImg = 4'($urandom);
    end
    settle();
    checkOutput("rst_busy", oBusy, 1'b0);
    checkOutput("rst_twreal", oTwReal, 64'h0);
    checkOutput("rst_accreal", oAccReal, 64'h0);
    tick();
    applyStimulus(0, 0, 0, 0, 8'h00, 8'h00);
    iCoreReal = '0; iCoreImg = '0;
    iRstN = 1'b1;
    repeat (3) tick();
    checkOutput("idle_busy", oBusy, 1'b0);

    // Twiddle load with a gap, then a constant-pattern frame
    settle();
    snap();
    applyStimulus(1, 0, 0, 0, 8'h00, 8'h00); tick();
    applyStimulus(0, 0, 0, 1, 8'h40, 8'hC0); tick();
    applyStimulus(0, 0, 0, 0, 8'h00, 8'h00); tick();
    applyStimulus(0, 0, 0, 1, 8'h7F, 8'h00); tick();
    applyStimulus(0, 0, 0, 0, 8'h00, 8'h00);
    iCoreReal = 4'b0001; iCoreImg = 4'b1010;
    settle();
    sWready = wreadyCount;
    runFrame(0);
    settle();
    checkOutput("lit_twreal", oTwReal, 64'h7F40);
    checkOutput("lit_twimg", oTwImg, 64'h00C0);
    checkOutput("lit_en_cycles", enCount - sEn, 18);
    checkOutput("lit_done_pulses", doneCount - sDone, 1);
    checkOutput("lit_clr_pulses", clrCount - sClr, 1);
    checkOutput("lit_loadw_pulses", loadwCount - sLoadw, 1);
    checkOutput("lit_wready_after", wreadyCount - sWready, 0);
    checkOutput("lit_accreal", oAccReal, 64'h00010);
    checkOutput("lit_accimg", oAccImg, 64'h80200);
    checkOutput("lit_valid", oValid, 1'b1);

    // Latency discard with stored twiddles
    snap();
    iCoreReal = '0; iCoreImg = '0;
    applyStimulus(1, 1, 0, 0, 8'h00, 8'h00); tick();
    applyStimulus(0, 0, 0, 0, 8'h00, 8'h00);
    runFrame(1);
    settle();
    checkOutput("lit_latency_accreal", oAccReal, 64'h00001);
    checkOutput("lit_latency_accimg", oAccImg, 64'h0);
    checkOutput("lit_keep_wready", wreadyCount - sWready, 0);
    checkOutput("lit_keep_twreal", oTwReal, 64'h7F40);
    checkOutput("lit_keep_clr", clrCount - sClr, 1);

    // Stray iStart during RUN
    snap();
    iCoreReal = 4'b1111; iCoreImg = 4'b0000;
    applyStimulus(1, 1, 0, 0, 8'h00, 8'h00); tick();
    applyStimulus(0, 0, 0, 0, 8'h00, 8'h00);
    runFrame(3);
    settle();
    checkOutput("lit_stray_done", doneCount - sDone, 1);
    checkOutput("lit_stray_en", enCount - sEn, 18);
    checkOutput("lit_stray_accreal", oAccReal, 64'h84210);
    checkOutput("lit_stray_wready", wreadyCount - sWready, 0);

    // Abort at r=5 together with iStart
    snap();
    applyStimulus(1, 1, 0, 0, 8'h00, 8'h00); tick();
    applyStimulus(0, 0, 0, 0, 8'h00, 8'h00);
    waitRun(5);
    applyStimulus(1, 0, 1, 0, 8'h00, 8'h00); tick();
    applyStimulus(0, 0, 0, 0, 8'h00, 8'h00);
    settle();
    checkOutput("lit_abort_en", oCoreEn, 1'b0);
    checkOutput("lit_abort_busy", oBusy, 1'b0);
    checkOutput("lit_abort_valid", oValid, 1'b0);
    repeat (3) tick();
    settle();
    checkOutput("lit_abort_done", doneCount - sDone, 0);
    checkOutput("lit_abort_stays_idle", oBusy, 1'b0);

    // Random traffic checked against the model
    repeat (1500) begin
      tick();
      applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 49) == 0,
                    $urandom_range(0, 1) == 1, 8'($urandom), 8'($urandom));
      iCoreReal = 4'($urandom); iCoreImg = 4'($urandom);
    end
    applyStimulus(0, 0, 0, 0, 8'h00, 8'h00);
    repeat (30) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/sfft_frame_engine.md
Name: sfft_frame_engine

Overview:
- Frame controller and output integrator for the stochastic (unary-bitstream) FFT butterfly network.
- Loads one complex twiddle pair per butterfly stage, replacing the single shared twiddle used so far. Drives the network's enable, clear and load-weight controls for one fixed-length bitstream frame.
- Counts the ones on every real and imaginary output stream into binary accumulators, then signals completion with a valid/done handshake.

Parameters:
- BITWIDTH, 8, twiddle word width (binary, fed to per-stage SNG weights).
- NUMINPUTS, 4, FFT points / bitstream channels; power of two, >= 2.
- LOG2N, $clog2(NUMINPUTS), number of butterfly stages = twiddle words per frame.
- STREAMLEN, 256, counted bitstream length per frame, in cycles.
- CORELAT, 2, network pipeline latency; leading output cycles discarded.
- CNTW, $clog2(STREAMLEN+1), accumulator width per channel.

Ports:
- iClk  in  1  clock.
- iRstN  in  1  asynchronous active-low reset.
- iStart  in  1  start frame (sampled in IDLE only).
- iKeepW  in  1  with iStart: reuse stored twiddles, skip LOAD.
- iAbort  in  1  abandon frame.
- iWValid  in  1  twiddle word valid.
- iWReal  in  BITWIDTH  twiddle real part.
- iWImg  in  BITWIDTH  twiddle imaginary part.
- oWReady  out  1  twiddle word accepted when iWValid & oWReady.
- oTwReal  out  LOG2N*BITWIDTH  per-stage twiddle real; stage s at [s*BITWIDTH +: BITWIDTH].
- oTwImg  out  LOG2N*BITWIDTH  per-stage twiddle imaginary, same packing.
- oCoreEn  out  1  network enable.
- oCoreClr  out  1  network clear.
- oCoreLoadW  out  1  network weight load.
- iCoreReal  in  NUMINPUTS  network real output bitstreams.
- iCoreImg  in  NUMINPUTS  network imaginary output bitstreams.
- oAccReal  out  NUMINPUTS*CNTW  ones count per real channel k at [k*CNTW +: CNTW].
- oAccImg  out  NUMINPUTS*CNTW  ones count per imaginary channel.
- oBusy  out  1  state != IDLE.
- oValid  out  1  accumulators hold a completed frame.
- oDone  out  1  one-cycle completion pulse.

Behaviour:
- Reset (iRstN=0, async): state IDLE. All outputs 0, including twiddle registers, accumulators, oWReady, oValid and oDone.
- All control outputs are registered.

FSM:
- IDLE: iStart=1 -> LOAD; with iKeepW=1 -> CLEAR. On start, oValid <= 0 and all accumulators <= 0.
- LOAD: oWReady=1. Each accepted word is written to stage index 0 first, then 1, 2, …. After the LOG2N-th accept -> CLEAR. iWValid gaps simply stall; no timeout.
- CLEAR: exactly 1 cycle. oCoreClr=1, oCoreLoadW=1, oCoreEn=0. Next state is RUN.
- RUN: oCoreEn=1 for exactly CORELAT+STREAMLEN cycles.
  - Run counter r runs 0 … CORELAT+STREAMLEN-1.
  - When r >= CORELAT, each accumulator adds its input bit.
  - After the last cycle -> DONE.
- DONE: 1 cycle. oDone=1, oValid <= 1, oCoreEn=0. Next state is IDLE.

Handshake and control rules:
- oValid stays 1 until the next accepted iStart, or until reset.
- iStart outside IDLE: ignored.
- iWValid outside LOAD: ignored.
- iAbort: any non-IDLE state -> IDLE on the next edge.
  - All core controls drop and no oDone is generated.
  - oValid stays 0; accumulators keep their partial values; twiddles already written are kept.
  - iAbort has priority over iStart and over every state transition in the same cycle.

Arithmetic:
- Accumulator maximum is STREAMLEN. CNTW guarantees no overflow, so no saturation logic is needed.
- Bipolar conversion (2*acc - STREAMLEN) is downstream, not in this block.

Test Plan:
1. Reset, parameters N=4, STREAMLEN=16, CORELAT=2: hold iRstN=0 with random inputs -> all outputs 0. Release -> oBusy stays 0 until iStart.
2. iStart, then twiddles (0x40,0xC0) and (0x7F,0x00), with one idle iWValid cycle between them -> oTwReal=0x7F40 and oTwImg=0x00C0. Exactly one oCoreLoadW/oCoreClr pulse follows the 2nd accept, and oWReady stays 0 afterwards.
3. RUN with iCoreReal=4'b0001 constant and iCoreImg=4'b1010 constant -> oCoreEn high exactly 18 cycles. Then oAccReal ch0=16, ch1–3=0; oAccImg ch1=ch3=16, ch0=ch2=0. oDone high exactly 1 cycle, oValid=1.
4. Latency discard: iCoreReal[0]=1 only during RUN cycles r=0,1 and again at r=17 -> oAccReal ch0=1.
5. iAbort at RUN r=5 -> next cycle state IDLE, oCoreEn=0, oBusy=0, no oDone, oValid=0. An iStart asserted in the same cycle as iAbort is ignored.
6. After a completed frame: iStart with iKeepW=1 -> oWReady never asserts, twiddles unchanged, CLEAR follows the start. An iStart pulse during RUN is ignored: exactly one oDone.
